// File: rtl/bp_me_pkg.sv
// Shared definitions for the memory-end register blocks: timer register
// selectors and the byte-mask helper used by sub-word register writes.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_timer_mtime    = 2'd0,
        e_timer_mtimecmp = 2'd1,
        e_timer_msip     = 2'd2
    } bp_timer_reg_e;

    localparam int timer_regs_gp = 3;

    // Bytes touched by an access of 2^size bytes at byte offset off; bytes past 7 fall off.
    function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [1:0] size);
        logic [15:0] span;
        span = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
        return span[7:0];
    endfunction

endpackage

// File: rtl/bp_me_reg_byte_merge.sv
// Combinational byte-lane merge of right-aligned write data into a 64-bit register.
module bp_me_reg_byte_merge
    import bp_me_pkg::*;
(
    input  logic [63:0] old_val,
    input  logic [63:0] data,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    output logic [63:0] merged,
    output logic [7:0]  mask
);

    logic [63:0] lane;

    always_comb begin
        mask   = byte_mask(off, size);
        lane   = data << {off, 3'b000};
        merged = old_val;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = lane[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/bp_me_timer_regs.sv
// Machine-timer register file (mtime, mtimecmp, msip) with latch-last-read
// read data and registered timer / software interrupt outputs.
module bp_me_timer_regs
    import bp_me_pkg::*;
#(
    parameter int reg_addr_width_p = 40,
    parameter int reg_size_width_p = 2,
    parameter int tick_div_p       = 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [timer_regs_gp-1:0]              r_v_i,
    input  logic [timer_regs_gp-1:0]              w_v_i,
    input  logic [reg_addr_width_p-1:0]           addr_i,
    input  logic [reg_size_width_p-1:0]           size_i,
    input  logic [63:0]                           data_i,
    output logic [timer_regs_gp-1:0][63:0]        data_o,
    output logic                                  timer_irq_o,
    output logic                                  software_irq_o
);

    localparam int tick_width_lp = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
    localparam logic [tick_width_lp-1:0] tick_last_lp = tick_width_lp'(tick_div_p - 1);

    logic [tick_width_lp-1:0] prescale;
    logic                     tick;
    logic [63:0]              mtime, mtimecmp;
    logic                     msip;

    logic [2:0]  off;
    logic [1:0]  size;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_merged, mtimecmp_merged, msip_merged;
    logic [7:0]  mtime_mask, mtimecmp_mask, msip_mask;
    logic [63:0] mtime_next, mtimecmp_next;
    logic        msip_next;
    logic [timer_regs_gp-1:0][63:0] reg_vals;
    logic        unused;

    assign off       = addr_i[2:0];
    assign size      = size_i[1:0];
    assign tick      = (prescale == tick_last_lp);
    assign mtime_inc = mtime + 64'(tick);
    assign reg_vals  = {{63'b0, msip}, mtimecmp, mtime};

    // Written mtime bytes replace the already-incremented value, so no carry crosses into them.
    bp_me_reg_byte_merge mtime_merge (
        .old_val (mtime_inc),
        .data    (data_i),
        .off     (off),
        .size    (size),
        .merged  (mtime_merged),
        .mask    (mtime_mask)
    );

    bp_me_reg_byte_merge mtimecmp_merge (
        .old_val (mtimecmp),
        .data    (data_i),
        .off     (off),
        .size    (size),
        .merged  (mtimecmp_merged),
        .mask    (mtimecmp_mask)
    );

    bp_me_reg_byte_merge msip_merge (
        .old_val ({63'b0, msip}),
        .data    (data_i),
        .off     (off),
        .size    (size),
        .merged  (msip_merged),
        .mask    (msip_mask)
    );

    assign mtime_next    = w_v_i[e_timer_mtime]    ? mtime_merged    : mtime_inc;
    assign mtimecmp_next = w_v_i[e_timer_mtimecmp] ? mtimecmp_merged : mtimecmp;
    assign msip_next     = w_v_i[e_timer_msip]     ? msip_merged[0]  : msip;

    assign unused = ^{addr_i[reg_addr_width_p-1:3], msip_merged[63:1],
                      mtime_mask, mtimecmp_mask, msip_mask};

    function automatic logic [63:0] read_align(input logic [63:0] value,
                                               input logic [2:0]  roff,
                                               input logic [1:0]  rsize);
        logic [63:0] shifted;
        shifted = value >> {roff, 3'b000};
        case (rsize)
            2'd0:    return {56'b0, shifted[7:0]};
            2'd1:    return {48'b0, shifted[15:0]};
            2'd2:    return {32'b0, shifted[31:0]};
            default: return shifted;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mtime          <= '0;
            mtimecmp       <= '1;
            msip           <= 1'b0;
            timer_irq_o    <= 1'b0;
            software_irq_o <= 1'b0;
            data_o         <= '0;
        end else begin
            mtime          <= mtime_next;
            mtimecmp       <= mtimecmp_next;
            msip           <= msip_next;
            timer_irq_o    <= (mtime_next >= mtimecmp_next);
            software_irq_o <= msip_next;
            for (int k = 0; k < timer_regs_gp; k++) begin
                if (r_v_i[k]) begin
                    data_o[k] <= read_align(reg_vals[k], off, size);
                end
            end
        end
    end

    a_strobe_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(r_v_i | w_v_i));
    a_no_read_write: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !((|r_v_i) && (|w_v_i)));

endmodule

// File: tb/tb_bp_me_timer_regs.sv
// Self-checking bench for bp_me_timer_regs: directed scenarios plus random
// traffic, compared every cycle against a byte-level behavioural model.
module tb_bp_me_timer_regs;

    localparam int DIV = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        r_v, w_v;
    logic [39:0]       addr;
    logic [1:0]        size;
    logic [63:0]       data;
    logic [2:0][63:0]  data_o;
    logic              timer_irq, software_irq;

    int errors = 0;
    int checks = 0;

    logic [63:0] m_mtime, m_cmp;
    logic [63:0] m_data [3];
    logic        m_msip, m_tirq, m_sirq;
    int unsigned m_cyc;

    bp_me_timer_regs #(
        .reg_addr_width_p (40),
        .reg_size_width_p (2),
        .tick_div_p       (DIV)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .r_v_i          (r_v),
        .w_v_i          (w_v),
        .addr_i         (addr),
        .size_i         (size),
        .data_i         (data),
        .data_o         (data_o),
        .timer_irq_o    (timer_irq),
        .software_irq_o (software_irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = '0; m_cmp = '1; m_msip = 1'b0;
        m_tirq = 1'b0; m_sirq = 1'b0; m_cyc = 0;
        for (int k = 0; k < 3; k++) m_data[k] = '0;
    endtask

    // One clock edge of the register file, computed from the current inputs.
    task automatic model_step();
        logic [63:0] cur [3];
        logic [63:0] nv  [3];
        logic [63:0] v;
        int          off, nb;
        bit          tick;
        cur[0] = m_mtime; cur[1] = m_cmp; cur[2] = {63'b0, m_msip};
        off = int'(addr[2:0]);
        nb  = 1 << size;
        for (int k = 0; k < 3; k++) begin
            if (r_v[k]) begin
                v = cur[k] >> (8 * off);
                if (nb < 8) v = v & ((64'd1 << (8 * nb)) - 64'd1);
                m_data[k] = v;
            end
        end
        tick = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        nv[0] = m_mtime + 64'(tick);
        nv[1] = m_cmp;
        nv[2] = cur[2];
        for (int k = 0; k < 3; k++) begin
            if (w_v[k]) begin
                for (int b = off; b < off + nb && b < 8; b++) begin
                    nv[k][8*b +: 8] = data[8*(b-off) +: 8];
                end
            end
        end
        m_mtime = nv[0];
        m_cmp   = nv[1];
        m_msip  = nv[2][0];
        m_tirq  = (m_mtime >= m_cmp);
        m_sirq  = m_msip;
    endtask

    task automatic compare_all();
        check_val("data_mtime",    data_o[0], m_data[0]);
        check_val("data_mtimecmp", data_o[1], m_data[1]);
        check_val("data_msip",     data_o[2], m_data[2]);
        check_val("timer_irq",     64'(timer_irq), 64'(m_tirq));
        check_val("software_irq",  64'(software_irq), 64'(m_sirq));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic op(input logic [2:0] r, input logic [2:0] w, input logic [2:0] off,
                      input logic [1:0] sz, input logic [63:0] d);
        r_v = r; w_v = w; size = sz; data = d;
        addr = {5'($urandom), 32'($urandom), off};
        step();
        r_v = '0; w_v = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next edge is a non-tick edge immediately followed by a tick edge.
    task automatic align_before_tick();
        while ((m_cyc % DIV) != DIV - 2) idle(1);
    endtask

    initial begin
        int          n;
        logic [2:0]  sel;
        logic [63:0] rd;
        reset_n = 1'b0;
        r_v = '0; w_v = '0; addr = '0; size = '0; data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        check_val("reset_data0", data_o[0], 64'd0);
        check_val("reset_tirq",  64'(timer_irq), 64'd0);
        check_val("reset_sirq",  64'(software_irq), 64'd0);
        reset_n = 1'b1;

        // Idle after reset: mtime advances once per DIV cycles.
        idle(40);
        check_val("idle_data1", data_o[1], 64'd0);
        check_val("idle_tirq",  64'(timer_irq), 64'd0);
        op(3'b001, 3'b000, 3'd0, 2'd3, 64'd0);
        check_val("mtime_after_40", data_o[0], 64'd10);

        // Compare match raises the timer irq; raising mtimecmp drops it.
        op(3'b000, 3'b010, 3'd0, 2'd3, 64'h20);
        n = 0;
        while (!timer_irq && n < 400) begin
            idle(1);
            n++;
        end
        check_val("tirq_rise", 64'(timer_irq), 64'd1);
        op(3'b001, 3'b000, 3'd0, 2'd3, 64'd0);
        check_val("mtime_at_match", data_o[0], 64'h20);
        op(3'b000, 3'b010, 3'd0, 2'd3, 64'h1000);
        check_val("tirq_fall", 64'(timer_irq), 64'd0);

        // Sub-word read at offset 4 is latched and held across ticks.
        op(3'b000, 3'b001, 3'd0, 2'd3, 64'h1_2345_6789);
        op(3'b001, 3'b000, 3'd4, 2'd2, 64'd0);
        check_val("read_hi_word", data_o[0], 64'h1);
        idle(8);
        check_val("read_held", data_o[0], 64'h1);

        // Byte write to mtime coincident with a tick.
        align_before_tick();
        op(3'b000, 3'b001, 3'd0, 2'd3, 64'h1FF);
        op(3'b000, 3'b001, 3'd0, 2'd0, 64'hFF);
        op(3'b001, 3'b000, 3'd0, 2'd3, 64'd0);
        check_val("write_vs_tick", data_o[0], 64'h2FF);

        // Software interrupt follows msip bit 0 only.
        op(3'b000, 3'b100, 3'd0, 2'd0, 64'h3);
        check_val("sirq_set", 64'(software_irq), 64'd1);
        op(3'b100, 3'b000, 3'd0, 2'd3, 64'd0);
        check_val("msip_read", data_o[2], 64'h1);
        op(3'b000, 3'b100, 3'd0, 2'd3, 64'h0);
        check_val("sirq_clear", 64'(software_irq), 64'd0);

        // mtime wrap with a small compare value.
        op(3'b000, 3'b010, 3'd0, 2'd3, 64'd5);
        align_before_tick();
        op(3'b000, 3'b001, 3'd0, 2'd3, '1);
        check_val("tirq_at_max", 64'(timer_irq), 64'd1);
        idle(1);
        check_val("tirq_after_wrap", 64'(timer_irq), 64'd0);
        op(3'b001, 3'b000, 3'd0, 2'd3, 64'd0);
        check_val("mtime_wrapped", data_o[0], 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            sel = 3'b001 << $urandom_range(0, 2);
            rd  = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) rd = 64'($urandom_range(0, 300));
            case ($urandom_range(0, 2))
                0: idle(1);
                1: op(sel, 3'b000, 3'($urandom), 2'($urandom), rd);
                default: op(3'b000, sel, 3'($urandom), 2'($urandom), rd);
            endcase
        end

        // Asynchronous reset in the middle of a write cycle.
        op(3'b010, 3'b000, 3'd0, 2'd3, 64'd0);
        op(3'b000, 3'b100, 3'd0, 2'd0, 64'h1);
        w_v = 3'b001; size = 2'd3; data = 64'hDEAD_BEEF; addr = '0;
        #3;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_data0", data_o[0], 64'd0);
        check_val("async_rst_data1", data_o[1], 64'd0);
        check_val("async_rst_data2", data_o[2], 64'd0);
        check_val("async_rst_tirq",  64'(timer_irq), 64'd0);
        check_val("async_rst_sirq",  64'(software_irq), 64'd0);
        w_v = '0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        model_reset();
        idle(6);
        op(3'b011 & 3'b010, 3'b000, 3'd0, 2'd3, 64'd0);
        check_val("cmp_after_reset", data_o[1], '1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
